// File: rtl/fhn_pkg.sv
// Shared definitions for the FHN spike encoder: widths, Q4.12 helpers,
// the spike detector state type and the event record layout.
package fhn_pkg;

  localparam int DATA_W     = 16;
  localparam int FRC_BITS   = 12;
  localparam int ISI_W      = 16;
  localparam int FIFO_DEPTH = 8;

  // Q4.12 scaling helpers (1.0 and 0.5)
  localparam int ONE  = 1 << FRC_BITS;
  localparam int HALF = 1 << (FRC_BITS - 1);

  typedef enum logic [1:0] {
    BELOW  = 2'd0,
    ABOVE  = 2'd1,
    REFRAC = 2'd2
  } spike_state_t;

  typedef struct packed {
    logic              first;
    logic [ISI_W-1:0]  isi;
    logic [DATA_W-1:0] vpeak;
  } spike_evt_t;

endpackage

// File: rtl/spike_evt_fifo.sv
// Synchronous event FIFO with a registered head. The head register keeps its
// last contents when the FIFO drains, so a consumer can still read the most
// recent event after evt_valid drops.
module spike_evt_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_nxt;
  logic [LVL_W-1:0] count;
  logic             do_pop;
  logic             do_push;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign level   = count;
  assign rd_nxt  = rd_ptr + PTR_W'(1);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array; a full FIFO may overwrite the slot being popped this cycle
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers, occupancy and the registered head that follows the next entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_nxt;
      if (do_push && !do_pop)      count <= count + LVL_W'(1);
      else if (do_pop && !do_push) count <= count - LVL_W'(1);
      if (do_push && (empty || (do_pop && count == LVL_W'(1))))
        dout <= din;
      else if (do_pop && count >= LVL_W'(2))
        dout <= mem[rd_nxt];
    end
  end

endmodule

// File: rtl/fhn_spike_encoder.sv
// Spike encoder: samples the membrane voltage, detects hysteretic threshold
// crossings, measures inter-spike interval and peak, and queues one event per
// spike in a small FIFO with a valid/ready output.
module fhn_spike_encoder #(
  parameter int DATA_W     = fhn_pkg::DATA_W,
  parameter int ISI_W      = fhn_pkg::ISI_W,
  parameter int FIFO_DEPTH = fhn_pkg::FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [DATA_W-1:0]             v_in,
  input  logic [DATA_W-1:0]             th_hi,
  input  logic [DATA_W-1:0]             th_lo,
  input  logic [7:0]                    refrac_cycles,
  output logic                          spike_pulse,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic                          evt_first,
  output logic [ISI_W-1:0]              evt_isi,
  output logic [DATA_W-1:0]             evt_vpeak,
  output logic [31:0]                   spike_count,
  output logic [15:0]                   drop_count,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import fhn_pkg::*;

  localparam int EVT_W = 1 + ISI_W + DATA_W;
  localparam logic [ISI_W-1:0] ISI_MAX = '1;

  spike_state_t             state;
  spike_state_t             state_nxt;
  logic signed [DATA_W-1:0] v_q;
  logic signed [DATA_W-1:0] peak;
  logic signed [DATA_W-1:0] th_hi_s;
  logic signed [DATA_W-1:0] th_lo_s;
  logic signed [DATA_W-1:0] th_lo_eff;
  logic [ISI_W-1:0]         isi_cnt;
  logic [ISI_W-1:0]         isi_inc;
  logic [ISI_W-1:0]         isi_lat;
  logic [7:0]               refrac_cnt;
  logic                     first_flag;
  logic                     onset;
  logic                     release_evt;
  logic                     pop;
  logic                     drop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [EVT_W-1:0]         push_data;
  logic [EVT_W-1:0]         head_data;

  assign th_hi_s   = $signed(th_hi);
  assign th_lo_s   = $signed(th_lo);
  // A release threshold above the onset threshold collapses onto it
  assign th_lo_eff = (th_lo_s < th_hi_s) ? th_lo_s : th_hi_s;
  // The reported ISI includes the onset cycle itself, so onsets N enabled
  // cycles apart report N
  assign isi_inc   = (isi_cnt == ISI_MAX) ? isi_cnt : isi_cnt + ISI_W'(1);

  // Input sample register; all detection works on this registered copy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) v_q <= '0;
    else if (en) v_q <= $signed(v_in);
  end

  // Detector state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BELOW;
    else        state <= state_nxt;
  end

  // Next-state decode plus the onset/release strobes; frozen while en is low
  always_comb begin
    state_nxt   = state;
    onset       = 1'b0;
    release_evt = 1'b0;
    if (en) begin
      case (state)
        BELOW: begin
          if (v_q >= th_hi_s) begin
            state_nxt = ABOVE;
            onset     = 1'b1;
          end
        end
        ABOVE: begin
          if (v_q < th_lo_eff) begin
            state_nxt   = REFRAC;
            release_evt = 1'b1;
          end
        end
        REFRAC: begin
          if (refrac_cnt <= 8'd1) state_nxt = BELOW;
        end
        default: state_nxt = BELOW;
      endcase
    end
  end

  // ISI, peak, refractory and spike counters driven by the strobes above
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt     <= '0;
      isi_lat     <= '0;
      peak        <= '0;
      refrac_cnt  <= '0;
      first_flag  <= 1'b1;
      spike_pulse <= 1'b0;
      spike_count <= '0;
    end else begin
      spike_pulse <= onset;
      if (en) begin
        isi_cnt <= onset ? '0 : isi_inc;
        if (onset) begin
          isi_lat     <= isi_inc;
          peak        <= v_q;
          spike_count <= spike_count + 32'd1;
        end else if (state == ABOVE && v_q > peak) begin
          peak <= v_q;
        end
        if (release_evt) begin
          first_flag <= 1'b0;
          refrac_cnt <= (refrac_cycles == 8'd0) ? 8'd1 : refrac_cycles;
        end else if (state == REFRAC && refrac_cnt != 8'd0) begin
          refrac_cnt <= refrac_cnt - 8'd1;
        end
      end
    end
  end

  assign push_data = {first_flag, isi_lat, peak};
  assign evt_valid = ~fifo_empty;
  assign pop       = evt_valid & evt_ready;
  assign drop      = release_evt & fifo_full & ~pop;

  // Saturating count of events lost to a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_count <= '0;
    else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
  end

  spike_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (release_evt),
    .din   (push_data),
    .pop   (pop),
    .dout  (head_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign evt_first = head_data[EVT_W-1];
  assign evt_isi   = head_data[DATA_W +: ISI_W];
  assign evt_vpeak = head_data[DATA_W-1:0];

endmodule
